uop_dispatch: RTL and testbench
===============================

// Module: uop_dispatch
// PURPOSE
//  Reader end of the decode uop queue. Pops decoded uops in order, checks RAW/WAW
//  hazards against a 32-entry register scoreboard, and issues each uop into a
//  registered issue slot for the ALU or the MUL unit over a valid/ready handshake.
//  Handles the HALT uop (drain, then stop) and excepting or illegal uops (stop and report).
// PARAMETERS
//  XLEN  32  datapath width of imm and pc fields
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  rst            in   1     reset; synchronous, active-low (rst==0 at posedge resets)
//  q_empty        in   1     decode queue empty; head fields valid when 0 (show-ahead)
//  q_uop          in   7     head uop: 7'b010_0000 ALU, 7'b100_0000 MUL, 7'b111_1111 HALT
//  q_eoi          in   1     head end-of-instruction flag
//  q_imm          in   XLEN  head immediate
//  q_use_imm      in   1     head uses imm in place of src2
//  q_src1/q_src2  in   5     head architectural sources
//  q_dest         in   5     head architectural destination
//  q_pc           in   XLEN  head pc
//  q_except       in   1     head carries exception
//  q_rd           out  1     pop strobe, combinational, asserted in the dispatch cycle
//  alu_valid/mul_valid  out 1  issue slot holds a uop
//  alu_ready/mul_ready  in  1  unit accepts slot contents this cycle
//  iss_imm/iss_use_imm/iss_src1/iss_src2/iss_dest/iss_pc/iss_eoi  out  per q_*
//                 payload of each slot, prefixed alu_ and mul_
//  alu_wb_valid/mul_wb_valid  in 1   writeback from unit, clears scoreboard bit
//  alu_wb_rd/mul_wb_rd        in 5   writeback destination
//  flush          in   1     leave EXC, empty both issue slots
//  exc_valid      out  1     exception pending (state EXC)
//  exc_pc         out  XLEN  pc of excepting uop
//  halted         out  1     state HALTED
//  disp_count     out  32    uops issued since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: all outputs 0, scoreboard 0, both slots empty, state RUN.
//  States: RUN -> DRAIN (HALT popped); DRAIN -> HALTED (scoreboard==0, both slots empty);
//  RUN -> EXC (head q_except=1 or q_uop not ALU/MUL/HALT); EXC -> RUN on flush.
//  HALTED is left only by reset.
//  Hazard: busy(r)=sb[r] && r!=0. Stall if busy(src1), busy(src2) && !q_use_imm,
//  or busy(dest). Check uses registered sb; no same-cycle writeback bypass.
//  Dispatch when: RUN, !q_empty, legal, no hazard, target slot free or its ready=1 this cycle.
//  Dispatch cycle: q_rd=1. Next edge: slot loaded, valid=1, sb[dest] set (dest!=0),
//  disp_count+1. Latency pop->valid = 1 cycle; back-to-back 1 uop/cycle with ready held 1.
//  Slot: valid held with payload stable until valid&&ready; then cleared unless reloaded same edge.
//  HALT: popped with q_rd=1, no slot written, no count. Excepting uop is not popped; exc_pc=q_pc.
//  Scoreboard: both wb ports clear bits in the same cycle; rd 0 ignored.
//  Set and clear of the same bit in one cycle: set wins.
//  flush: both slots cleared at next edge; sb untouched (in-flight writebacks still clear).
//  flush in RUN/DRAIN empties slots only, state unchanged. In HALTED, flush has no effect.
//  Reset mid-operation discards slots, scoreboard and state without handshake.
//  Only one uop is popped per cycle, in order; a stalled head blocks younger uops.
// TESTING
//  ADDI x1 then ADD x2,x1,x3 -> ADD stalls until alu_wb_valid rd=1; issues 2 cycles after wb.
//  ALU, MUL, ALU with readys=1 and no deps -> q_rd 3 consecutive cycles, disp_count=3.
//  mul_ready=0 for 5 cycles -> mul slot payload stable; next MUL head held, q_rd=0.
//  uop 7'h11 at pc 0x40 -> exc_valid=1, exc_pc=0x40, q_rd=0; flush -> RUN next cycle.
//  HALT behind MUL to x5 -> halted stays 0 until mul_wb rd=5, then 1 next cycle.
//  rst=0 mid-stall -> all outputs 0 next edge; ADD x0 -> sb stays 0.

Source files
------------

// File: rtl/uop_dispatch.sv
// Decode-queue reader: in-order pop, scoreboard RAW/WAW hazard check, and issue into
// registered ALU/MUL slots. HALT drains then stops; excepting or illegal uops stop and report.
module uop_dispatch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            q_empty,
  input  logic [6:0]      q_uop,
  input  logic            q_eoi,
  input  logic [XLEN-1:0] q_imm,
  input  logic            q_use_imm,
  input  logic [4:0]      q_src1,
  input  logic [4:0]      q_src2,
  input  logic [4:0]      q_dest,
  input  logic [XLEN-1:0] q_pc,
  input  logic            q_except,
  output logic            q_rd,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic [XLEN-1:0] alu_imm,
  output logic            alu_use_imm,
  output logic [4:0]      alu_src1,
  output logic [4:0]      alu_src2,
  output logic [4:0]      alu_dest,
  output logic [XLEN-1:0] alu_pc,
  output logic            alu_eoi,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic [XLEN-1:0] mul_imm,
  output logic            mul_use_imm,
  output logic [4:0]      mul_src1,
  output logic [4:0]      mul_src2,
  output logic [4:0]      mul_dest,
  output logic [XLEN-1:0] mul_pc,
  output logic            mul_eoi,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic            mul_wb_valid,
  input  logic [4:0]      mul_wb_rd,
  input  logic            flush,
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_pc,
  output logic            halted,
  output logic [31:0]     disp_count
);

  localparam logic [6:0] UOP_ALU  = 7'b010_0000;
  localparam logic [6:0] UOP_MUL  = 7'b100_0000;
  localparam logic [6:0] UOP_HALT = 7'b111_1111;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_EXC} state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [4:0]      src1;
    logic [4:0]      src2;
    logic [4:0]      dest;
    logic [XLEN-1:0] pc;
    logic            eoi;
  } slot_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_sb, w_sb_next, w_sb_set, w_sb_clr, w_busy;
  logic            r_alu_valid, r_mul_valid, w_alu_valid_next, w_mul_valid_next;
  slot_t           r_alu, r_mul, w_head;
  logic [31:0]     r_count;
  logic [XLEN-1:0] r_exc_pc;

  logic w_is_alu, w_is_mul, w_is_halt, w_legal, w_head_live, w_hazard;
  logic w_go_exc, w_halt_pop, w_disp_alu, w_disp_mul, w_dispatch;

  assign w_head = '{imm: q_imm, use_imm: q_use_imm, src1: q_src1, src2: q_src2,
                    dest: q_dest, pc: q_pc, eoi: q_eoi};

  assign w_is_alu  = (q_uop == UOP_ALU);
  assign w_is_mul  = (q_uop == UOP_MUL);
  assign w_is_halt = (q_uop == UOP_HALT);
  assign w_legal   = w_is_alu | w_is_mul | w_is_halt;

  // x0 is never busy; hazards look only at the registered scoreboard.
  assign w_busy   = r_sb & ~32'h1;
  assign w_hazard = w_busy[q_src1] | (w_busy[q_src2] & ~q_use_imm) | w_busy[q_dest];

  assign w_head_live = rst && (r_state == S_RUN) && !q_empty;
  assign w_go_exc    = w_head_live && (q_except || !w_legal);
  assign w_halt_pop  = w_head_live && !q_except && w_is_halt;
  // Dispatch is held off during flush so a popped uop is never thrown away.
  assign w_disp_alu  = w_head_live && !q_except && !flush && w_is_alu && !w_hazard &&
                       (!r_alu_valid || alu_ready);
  assign w_disp_mul  = w_head_live && !q_except && !flush && w_is_mul && !w_hazard &&
                       (!r_mul_valid || mul_ready);
  assign w_dispatch  = w_disp_alu | w_disp_mul;

  assign q_rd = w_dispatch | w_halt_pop;

  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (alu_wb_valid) w_sb_clr[alu_wb_rd] = 1'b1;
    if (mul_wb_valid) w_sb_clr[mul_wb_rd] = 1'b1;
    if (w_dispatch)   w_sb_set[q_dest]    = 1'b1;
    w_sb_next    = (r_sb & ~w_sb_clr) | w_sb_set;
    w_sb_next[0] = 1'b0;
  end

  always_comb begin
    w_alu_valid_next = r_alu_valid;
    w_mul_valid_next = r_mul_valid;
    if (w_disp_alu)              w_alu_valid_next = 1'b1;
    else if (flush || alu_ready) w_alu_valid_next = 1'b0;
    if (w_disp_mul)              w_mul_valid_next = 1'b1;
    else if (flush || mul_ready) w_mul_valid_next = 1'b0;
  end

  // DRAIN finishes on the edge that retires the last writeback and empties the slots.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN: begin
        if (w_go_exc)        w_state_next = S_EXC;
        else if (w_halt_pop) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((w_sb_next == '0) && !w_alu_valid_next && !w_mul_valid_next)
          w_state_next = S_HALTED;
      end
      S_EXC: begin
        if (flush) w_state_next = S_RUN;
      end
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_sb        <= '0;
      r_alu_valid <= 1'b0;
      r_mul_valid <= 1'b0;
      r_alu       <= '0;
      r_mul       <= '0;
      r_count     <= '0;
      r_exc_pc    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sb        <= w_sb_next;
      r_alu_valid <= w_alu_valid_next;
      r_mul_valid <= w_mul_valid_next;
      if (w_disp_alu) r_alu <= w_head;
      if (w_disp_mul) r_mul <= w_head;
      if (w_dispatch) r_count <= r_count + 32'd1;
      if (w_go_exc)   r_exc_pc <= q_pc;
    end
  end

  assign alu_valid   = r_alu_valid;
  assign alu_imm     = r_alu.imm;
  assign alu_use_imm = r_alu.use_imm;
  assign alu_src1    = r_alu.src1;
  assign alu_src2    = r_alu.src2;
  assign alu_dest    = r_alu.dest;
  assign alu_pc      = r_alu.pc;
  assign alu_eoi     = r_alu.eoi;
  assign mul_valid   = r_mul_valid;
  assign mul_imm     = r_mul.imm;
  assign mul_use_imm = r_mul.use_imm;
  assign mul_src1    = r_mul.src1;
  assign mul_src2    = r_mul.src2;
  assign mul_dest    = r_mul.dest;
  assign mul_pc      = r_mul.pc;
  assign mul_eoi     = r_mul.eoi;
  assign exc_valid   = (r_state == S_EXC);
  assign exc_pc      = r_exc_pc;
  assign halted      = (r_state == S_HALTED);
  assign disp_count  = r_count;

endmodule

// File: tb/tb_uop_dispatch.sv
// Directed bench for uop_dispatch: hand-computed expectations checked with immediate assertions.
module tb_uop_dispatch;

  localparam int XLEN = 32;
  localparam logic [6:0] ALU  = 7'h20;
  localparam logic [6:0] MUL  = 7'h40;
  localparam logic [6:0] HALT = 7'h7F;

  logic            clk = 1'b0;
  logic            rst;
  logic            q_empty, q_eoi, q_use_imm, q_except, q_rd;
  logic [6:0]      q_uop;
  logic [XLEN-1:0] q_imm, q_pc;
  logic [4:0]      q_src1, q_src2, q_dest;
  logic            alu_valid, alu_ready, alu_use_imm, alu_eoi;
  logic [XLEN-1:0] alu_imm, alu_pc;
  logic [4:0]      alu_src1, alu_src2, alu_dest;
  logic            mul_valid, mul_ready, mul_use_imm, mul_eoi;
  logic [XLEN-1:0] mul_imm, mul_pc;
  logic [4:0]      mul_src1, mul_src2, mul_dest;
  logic            alu_wb_valid, mul_wb_valid, flush, exc_valid, halted;
  logic [4:0]      alu_wb_rd, mul_wb_rd;
  logic [XLEN-1:0] exc_pc;
  logic [31:0]     disp_count;

  int checks = 0;
  int errors = 0;

  uop_dispatch #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_uop(q_uop), .q_eoi(q_eoi),
    .q_imm(q_imm), .q_use_imm(q_use_imm), .q_src1(q_src1), .q_src2(q_src2),
    .q_dest(q_dest), .q_pc(q_pc), .q_except(q_except), .q_rd(q_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_imm(alu_imm),
    .alu_use_imm(alu_use_imm), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_dest(alu_dest), .alu_pc(alu_pc), .alu_eoi(alu_eoi),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_imm(mul_imm),
    .mul_use_imm(mul_use_imm), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_dest(mul_dest), .mul_pc(mul_pc), .mul_eoi(mul_eoi),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .mul_wb_valid(mul_wb_valid), .mul_wb_rd(mul_wb_rd),
    .flush(flush), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .halted(halted), .disp_count(disp_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic empty, input logic [6:0] uop,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic uimm,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic exc);
    q_empty = empty; q_uop = uop; q_src1 = s1; q_src2 = s2; q_dest = d;
    q_use_imm = uimm; q_imm = imm; q_pc = pc; q_except = exc; q_eoi = 1'b1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; alu_ready = 1'b1; mul_ready = 1'b1;
    alu_wb_valid = 1'b0; alu_wb_rd = '0; mul_wb_valid = 1'b0; mul_wb_rd = '0;
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checkOutput("reset_alu_valid", alu_valid, 0);
    checkOutput("reset_mul_valid", mul_valid, 0);
    checkOutput("reset_halted", halted, 0);
    checkOutput("reset_exc", exc_valid, 0);
    checkOutput("reset_count", disp_count, 0);
    rst = 1'b1;
    tick();

    $display("[TB] back-to-back ALU MUL ALU");
    applyStimulus(0, ALU, 0, 0, 10, 0, 0, 32'h10, 0);
    checkOutput("b2b_rd0", q_rd, 1);
    tick();
    checkOutput("b2b_alu_v0", alu_valid, 1);
    checkOutput("b2b_alu_dest0", alu_dest, 10);
    applyStimulus(0, MUL, 0, 0, 11, 0, 0, 32'h14, 0);
    checkOutput("b2b_rd1", q_rd, 1);
    tick();
    checkOutput("b2b_mul_v", mul_valid, 1);
    checkOutput("b2b_alu_drop", alu_valid, 0);
    applyStimulus(0, ALU, 0, 0, 12, 0, 0, 32'h18, 0);
    checkOutput("b2b_rd2", q_rd, 1);
    tick();
    checkOutput("b2b_alu_dest2", alu_dest, 12);
    checkOutput("b2b_count", disp_count, 3);
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    alu_wb_valid = 1; alu_wb_rd = 10; mul_wb_valid = 1; mul_wb_rd = 11;
    tick();
    mul_wb_valid = 0; alu_wb_rd = 12;
    tick();
    alu_wb_valid = 0;

    $display("[TB] RAW stall ADDI x1 -> ADD x2,x1,x3");
    applyStimulus(0, ALU, 0, 0, 1, 1, 32'h5, 32'h20, 0);
    checkOutput("raw_addi_rd", q_rd, 1);
    tick();
    checkOutput("raw_addi_imm", alu_imm, 5);
    applyStimulus(0, ALU, 1, 3, 2, 0, 0, 32'h24, 0);
    checkOutput("raw_stall_rd", q_rd, 0);
    tick(); tick();
    checkOutput("raw_stall_rd2", q_rd, 0);
    alu_wb_valid = 1; alu_wb_rd = 1;
    #1;
    checkOutput("raw_no_bypass", q_rd, 0);
    tick();
    alu_wb_valid = 0;
    #1;
    checkOutput("raw_release_rd", q_rd, 1);
    checkOutput("raw_not_yet_valid", alu_valid, 0);
    tick();
    checkOutput("raw_add_valid", alu_valid, 1);
    checkOutput("raw_add_src1", alu_src1, 1);
    checkOutput("raw_count", disp_count, 5);
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    alu_wb_valid = 1; alu_wb_rd = 2;
    tick();
    alu_wb_valid = 0;

    $display("[TB] MUL backpressure");
    mul_ready = 0;
    applyStimulus(0, MUL, 0, 0, 5, 0, 0, 32'h100, 0);
    checkOutput("bp_rd0", q_rd, 1);
    tick();
    applyStimulus(0, MUL, 0, 0, 6, 0, 0, 32'h104, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", mul_valid, 1);
      checkOutput("bp_hold_pc", mul_pc, 32'h100);
      checkOutput("bp_hold_rd", q_rd, 0);
      tick();
    end
    mul_ready = 1;
    #1;
    checkOutput("bp_release_rd", q_rd, 1);
    tick();
    checkOutput("bp_next_pc", mul_pc, 32'h104);
    checkOutput("bp_count", disp_count, 7);
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    mul_wb_valid = 1; mul_wb_rd = 5; alu_wb_valid = 1; alu_wb_rd = 6;
    tick();
    mul_wb_valid = 0; alu_wb_valid = 0;
    checkOutput("bp_drained", mul_valid, 0);

    $display("[TB] illegal uop");
    applyStimulus(0, 7'h11, 0, 0, 0, 0, 0, 32'h40, 0);
    checkOutput("exc_rd", q_rd, 0);
    tick();
    checkOutput("exc_valid", exc_valid, 1);
    checkOutput("exc_pc", exc_pc, 32'h40);
    checkOutput("exc_hold_rd", q_rd, 0);
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1;
    tick();
    flush = 0;
    checkOutput("exc_flushed", exc_valid, 0);

    $display("[TB] HALT behind MUL x5");
    applyStimulus(0, MUL, 0, 0, 5, 0, 0, 32'h200, 0);
    checkOutput("halt_mul_rd", q_rd, 1);
    tick();
    applyStimulus(0, HALT, 0, 0, 0, 0, 0, 32'h204, 0);
    checkOutput("halt_pop_rd", q_rd, 1);
    tick();
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_count", disp_count, 8);
    tick(); tick();
    checkOutput("halt_wait", halted, 0);
    mul_wb_valid = 1; mul_wb_rd = 5;
    tick();
    mul_wb_valid = 0;
    checkOutput("halt_done", halted, 1);
    applyStimulus(0, ALU, 0, 0, 3, 0, 0, 32'h208, 0);
    checkOutput("halt_no_pop", q_rd, 0);
    flush = 1;
    tick();
    flush = 0;
    checkOutput("halt_flush_ignored", halted, 1);

    $display("[TB] reset mid-stall");
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    tick();
    rst = 1;
    alu_ready = 0;
    applyStimulus(0, ALU, 0, 0, 7, 0, 0, 32'h300, 0);
    tick();
    applyStimulus(0, ALU, 7, 0, 8, 0, 0, 32'h304, 0);
    checkOutput("rst_stall_rd", q_rd, 0);
    rst = 0;
    #1;
    checkOutput("rst_no_pop", q_rd, 0);
    tick();
    checkOutput("rst_alu_valid", alu_valid, 0);
    checkOutput("rst_count", disp_count, 0);
    checkOutput("rst_halted", halted, 0);
    rst = 1; alu_ready = 1;
    applyStimulus(0, ALU, 0, 0, 0, 0, 0, 32'h308, 0);
    checkOutput("rst_sb_clear_rd", q_rd, 1);
    tick();
    checkOutput("x0_dest", alu_dest, 0);
    applyStimulus(0, ALU, 0, 0, 0, 0, 0, 32'h30C, 0);
    checkOutput("x0_no_busy_rd", q_rd, 1);
    tick();
    checkOutput("x0_count", disp_count, 2);
    applyStimulus(1, '0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
